instruction_sequencer: RTL

- Upstream fetch stage for the cpu core. Buffers a program of 32-bit instruction words, loaded one byte at a time from a host byte stream, in an internal program memory.
- On command, issues the words in order, one per cycle, as the cpu's current instruction.
- Stops on end of program or on a halt opcode. Supports a stall from downstream so the cpu can hold on multi-cycle tensor-core operations.

---
 rtl/instruction_sequencer_if.sv | 71 +++++++
 rtl/instruction_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer_if.sv
// Handshake and bus bundle between the host/cpu side and instruction_sequencer.
// The master modport is the host/cpu side, the slave modport is the sequencer.
// Optional single-step inputs exist only when INSTR_SEQ_SINGLE_STEP_EN is defined.
`timescale 1ns/1ps

interface instruction_sequencer_if #(
    parameter int ADDR_W = 6
);
    // Program download from the host byte stream
    logic              load_start_in;
    logic              load_valid_in;
    logic [7:0]        load_data_in;
    logic              load_ready_out;
    logic              load_done_in;

    // Execution control
    logic              start_in;
    logic              stall_in;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    logic              step_mode_in;
    logic              step_in;
`endif

    // Instruction stream and status towards the cpu
    logic [31:0]       current_instruction_out;
    logic              instruction_valid_out;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W:0]   program_length_out;
    logic              busy_out;
    logic              halted_out;

    modport master (
        output load_start_in,
        output load_valid_in,
        output load_data_in,
        input  load_ready_out,
        output load_done_in,
        output start_in,
        output stall_in,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        output step_mode_in,
        output step_in,
`endif
        input  current_instruction_out,
        input  instruction_valid_out,
        input  pc_out,
        input  program_length_out,
        input  busy_out,
        input  halted_out
    );

    modport slave (
        input  load_start_in,
        input  load_valid_in,
        input  load_data_in,
        output load_ready_out,
        input  load_done_in,
        input  start_in,
        input  stall_in,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        input  step_mode_in,
        input  step_in,
`endif
        output current_instruction_out,
        output instruction_valid_out,
        output pc_out,
        output program_length_out,
        output busy_out,
        output halted_out
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetch stage for the cpu core: downloads a program byte by byte into an
// internal word memory, then issues the words one per cycle as the cpu's
// current instruction until the end of the program or a halt opcode.
// Optional feature macro: INSTR_SEQ_SINGLE_STEP_EN adds step_mode_in/step_in
// so each word can be released to the cpu one step at a time.
`timescale 1ns/1ps

module instruction_sequencer #(
    parameter int          DEPTH       = 64,
    parameter int          ADDR_W      = $clog2(DEPTH),
    parameter logic [7:0]  HALT_OPCODE = 8'hFF,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input logic                   clock_in,
    input logic                   reset_n_in,
    instruction_sequencer_if.slave seqBus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } seqState_t;

    // Length value meaning "memory full"; sized to the length register.
    localparam logic [ADDR_W:0] FULL_LENGTH = (ADDR_W + 1)'(DEPTH);

    seqState_t        state_q, state_d;
    // pc carries one extra bit so that a full program can run to index DEPTH
    // without wrapping back onto word 0.
    logic [ADDR_W:0]  pc_q, pc_d;
    logic [ADDR_W:0]  programLength_q, programLength_d;
    logic [1:0]       byteCount_q, byteCount_d;
    // Only the first three bytes of a word need holding; the fourth byte is
    // merged straight into the memory write.
    logic [23:0]      assembly_q, assembly_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;

    logic [31:0]      programMem [DEPTH];
    logic             memWrEn;
    logic [ADDR_W-1:0] memWrAddr;
    logic [31:0]      memWrData;

    logic [31:0]      fetchWord;
    logic             loadReady;
    logic             byteAccept;
    logic             endOfProgram;
    logic             stepBlank;

    // Combinational fetch of the word at pc and download handshake terms.
    always_comb begin
        fetchWord    = programMem[pc_q[ADDR_W-1:0]];
        loadReady    = (state_q == ST_LOAD) && (programLength_q < FULL_LENGTH);
        byteAccept   = loadReady && seqBus.load_valid_in;
        endOfProgram = (pc_q == programLength_q) || (fetchWord[7:0] == HALT_OPCODE);
    end

    // In single-step mode the output is blanked on every cycle that is not a
    // clean step (step requested and no stall), so each word lasts one cycle.
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    always_comb begin
        stepBlank = seqBus.step_mode_in && (!seqBus.step_in || seqBus.stall_in);
    end
`else
    always_comb begin
        stepBlank = 1'b0;
    end
`endif

    // Next-state logic for the sequencer FSM, download datapath and issue path.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        programLength_d = programLength_q;
        byteCount_d     = byteCount_q;
        assembly_d      = assembly_q;
        instr_d         = instr_q;
        valid_d         = valid_q;
        memWrEn         = 1'b0;
        memWrAddr       = programLength_q[ADDR_W-1:0];
        memWrData       = {assembly_q, seqBus.load_data_in};

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (seqBus.load_start_in) begin
                    state_d         = ST_LOAD;
                    programLength_d = '0;
                    byteCount_d     = '0;
                end else if (seqBus.start_in) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end

            ST_LOAD: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (seqBus.load_start_in) begin
                    programLength_d = '0;
                    byteCount_d     = '0;
                end else begin
                    if (byteAccept) begin
                        if (byteCount_q == 2'd3) begin
                            memWrEn         = 1'b1;
                            programLength_d = programLength_q + 1'b1;
                            byteCount_d     = '0;
                        end else begin
                            assembly_d  = {assembly_q[15:0], seqBus.load_data_in};
                            byteCount_d = byteCount_q + 2'd1;
                        end
                    end
                    // A completed fourth byte above is still written; any
                    // shorter partial word is simply forgotten here.
                    if (seqBus.load_done_in) begin
                        state_d     = ST_IDLE;
                        byteCount_d = '0;
                    end
                end
            end

            ST_RUN: begin
                if (seqBus.load_start_in) begin
                    state_d         = ST_LOAD;
                    programLength_d = '0;
                    byteCount_d     = '0;
                    instr_d         = NOP_WORD;
                    valid_d         = 1'b0;
                end else if (stepBlank) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (seqBus.stall_in) begin
                    state_d = state_q;
                end else if (endOfProgram) begin
                    state_d = ST_HALT;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else begin
                    instr_d = fetchWord;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q         <= ST_IDLE;
            pc_q            <= '0;
            programLength_q <= '0;
            byteCount_q     <= '0;
            assembly_q      <= '0;
            instr_q         <= NOP_WORD;
            valid_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            programLength_q <= programLength_d;
            byteCount_q     <= byteCount_d;
            assembly_q      <= assembly_d;
            instr_q         <= instr_d;
            valid_q         <= valid_d;
        end
    end

    // Program memory write port; contents deliberately survive reset.
    always_ff @(posedge clock_in) begin
        if (memWrEn) begin
            programMem[memWrAddr] <= memWrData;
        end
    end

    // Output drive from registered state.
    always_comb begin
        seqBus.load_ready_out          = loadReady;
        seqBus.current_instruction_out = instr_q;
        seqBus.instruction_valid_out   = valid_q;
        seqBus.pc_out                  = pc_q[ADDR_W-1:0];
        seqBus.program_length_out      = programLength_q;
        seqBus.busy_out                = (state_q == ST_LOAD) || (state_q == ST_RUN);
        seqBus.halted_out              = (state_q == ST_HALT);
    end

endmodule
